// File: rtl/grf_wb_pkg.sv
// Shared types for the GRF write-port arbiter: register/data widths, the write entry
// carried by both producers, and the per-cycle grant source.
package grf_wb_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GntNone,
    GntWb,
    GntFifo,
    GntForce
  } grant_e;

endpackage

// File: rtl/grf_wb_fifo.sv
// DEPTH-entry circular FIFO of GRF write entries, with a per-slot address match vector
// so the hazard unit can search every held write in one cycle.
module grf_wb_fifo
  import grf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  wb_entry_t         push_entry_i,
  input  logic              pop_i,
  output wb_entry_t         head_o,
  output logic              empty_o,
  output logic              full_o,
  input  logic [REG_AW-1:0] q_addr_i,
  output logic [DEPTH-1:0]  match_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t       mem_q [DEPTH];
  wb_entry_t       mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  // A full FIFO refuses pushes even if the head pops in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // A slot holds a live entry when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic [PtrW-1:0] offs;
    assign offs       = PtrW'(i) - rd_ptr_q;
    assign match_o[i] = ({1'b0, offs} < count_q) && (mem_q[i].addr == q_addr_i);
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Arbitrates the GRF write port between WB and the MDU result FIFO with a starvation bound.
// Define GRF_WB_TRACE_EN to print a write trace and forced-grant notices in simulation.
module grf_wb_arbiter
  import grf_wb_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] wb_pc,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_AW-1:0] mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  input  logic [DATA_W-1:0] mdu_pc,
  input  logic [REG_AW-1:0] q_addr,
  output logic              q_pending,
  output logic              grf_we,
  output logic [REG_AW-1:0] grf_addr,
  output logic [DATA_W-1:0] grf_data,
  output logic [DATA_W-1:0] grf_pc
);

  localparam int unsigned StW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  wb_entry_t         wb_entry, mdu_entry, head, gnt_entry;
  logic              fifo_empty, fifo_full;
  logic              force_head, head_gnt;
  logic [DEPTH-1:0]  match;
  grant_e            grant;

  logic [StW-1:0]    starve_cnt_q, starve_cnt_d;
  logic              grf_we_q, grf_we_d;
  logic [REG_AW-1:0] grf_addr_q, grf_addr_d;
  logic [DATA_W-1:0] grf_data_q, grf_data_d;
  logic [DATA_W-1:0] grf_pc_q, grf_pc_d;

  assign wb_entry  = '{addr: wb_addr, data: wb_data, pc: wb_pc};
  assign mdu_entry = '{addr: mdu_addr, data: mdu_data, pc: mdu_pc};

  grf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (mdu_valid),
    .push_entry_i (mdu_entry),
    .pop_i        (head_gnt),
    .head_o       (head),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .q_addr_i     (q_addr),
    .match_o      (match)
  );

  // Ready signals depend on state only so producers never see a combinational loop.
  assign force_head = (starve_cnt_q == StW'(STARVE_LIMIT)) && !fifo_empty;
  assign wb_ready   = !force_head;
  assign mdu_ready  = !fifo_full;

  always_comb begin
    grant = GntNone;
    if (force_head) begin
      grant = GntForce;
    end else if (wb_valid) begin
      grant = GntWb;
    end else if (!fifo_empty) begin
      grant = GntFifo;
    end
  end

  assign head_gnt = (grant == GntForce) || (grant == GntFifo);

  always_comb begin
    gnt_entry    = (grant == GntWb) ? wb_entry : head;
    grf_we_d     = 1'b0;
    grf_addr_d   = grf_addr_q;
    grf_data_d   = grf_data_q;
    grf_pc_d     = grf_pc_q;
    starve_cnt_d = starve_cnt_q;
    if (grant != GntNone) begin
      // Writes to $0 still complete the handshake but never reach the grf.
      grf_we_d   = (gnt_entry.addr != '0);
      grf_addr_d = gnt_entry.addr;
      grf_data_d = gnt_entry.data;
      grf_pc_d   = gnt_entry.pc;
    end
    if (fifo_empty || head_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != StW'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + StW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      grf_we_q     <= 1'b0;
      grf_addr_q   <= '0;
      grf_data_q   <= '0;
      grf_pc_q     <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      grf_we_q     <= grf_we_d;
      grf_addr_q   <= grf_addr_d;
      grf_data_q   <= grf_data_d;
      grf_pc_q     <= grf_pc_d;
    end
  end

  assign grf_we   = grf_we_q;
  assign grf_addr = grf_addr_q;
  assign grf_data = grf_data_q;
  assign grf_pc   = grf_pc_q;

  assign q_pending = (q_addr != '0) && ((|match) || (grf_we_q && (grf_addr_q == q_addr)));

`ifdef GRF_WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && grf_we_q) begin
      $display("%0t@%08h: $%0d <= %08h", $time, grf_pc_q, grf_addr_q, grf_data_q);
    end
    if (!reset && (grant == GntForce)) begin
      $display("%0t: forced MDU grant $%0d", $time, head.addr);
    end
  end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: expected commits queued at stimulus time, popped and
// compared by a monitor whenever grf_we is high.
module tb_grf_wb_arbiter;
  import grf_wb_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              wb_valid, wb_ready;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data, wb_pc;
  logic              mdu_valid, mdu_ready;
  logic [REG_AW-1:0] mdu_addr;
  logic [DATA_W-1:0] mdu_data, mdu_pc;
  logic [REG_AW-1:0] q_addr;
  logic              q_pending;
  logic              grf_we;
  logic [REG_AW-1:0] grf_addr;
  logic [DATA_W-1:0] grf_data, grf_pc;

  int        checks   = 0;
  int        failures = 0;
  wb_entry_t exp_q[$];
  wb_entry_t mon_e;

  always #5 clk = ~clk;

  grf_wb_arbiter #(
    .DEPTH        (4),
    .STARVE_LIMIT (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_pc     (wb_pc),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_addr  (mdu_addr),
    .mdu_data  (mdu_data),
    .mdu_pc    (mdu_pc),
    .q_addr    (q_addr),
    .q_pending (q_pending),
    .grf_we    (grf_we),
    .grf_addr  (grf_addr),
    .grf_data  (grf_data),
    .grf_pc    (grf_pc)
  );

  // Scoreboard monitor: every grf write must be the next expected commit.
  always @(negedge clk) begin
    if (grf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL commit_unexpected: actual addr=%0d data=%h pc=%h required no commit",
                 grf_addr, grf_data, grf_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (grf_addr !== mon_e.addr || grf_data !== mon_e.data || grf_pc !== mon_e.pc) begin
          failures++;
          $display("FAIL commit_order: actual addr=%0d data=%h pc=%h required addr=%0d data=%h pc=%h",
                   grf_addr, grf_data, grf_pc, mon_e.addr, mon_e.data, mon_e.pc);
        end
      end
    end
    if (q_addr == '0) begin
      checks++;
      if (q_pending !== 1'b0) begin
        failures++;
        $display("FAIL q_pending_r0: actual=%b required=0", q_pending);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_commit(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    exp_q.push_back('{addr: a, data: d, pc: p});
  endtask

  task automatic drive_mdu(input logic v, input logic [4:0] a, input logic [31:0] d,
                           input logic [31:0] p);
    mdu_valid = v;
    mdu_addr  = a;
    mdu_data  = d;
    mdu_pc    = p;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: actual=%0d commits outstanding required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    reset    = 1'b1;
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    wb_pc    = '0;
    drive_mdu(1'b0, 5'd0, 32'h0, 32'h0);
    q_addr   = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check1("rst_wb_ready", wb_ready, 1'b1);
    check1("rst_mdu_ready", mdu_ready, 1'b1);
    check1("rst_grf_we", grf_we, 1'b0);
    check32("rst_grf_addr", 32'(grf_addr), 32'h0);
    check32("rst_grf_data", grf_data, 32'h0);
    check32("rst_grf_pc", grf_pc, 32'h0);

    // Single MDU push, commit two cycles later
    drive_mdu(1'b1, 5'd5, 32'h1234, 32'h3000);
    expect_commit(5'd5, 32'h1234, 32'h3000);
    q_addr = 5'd5;
    #1;
    check1("mdu1_qp_before", q_pending, 1'b0);
    tick();
    mdu_valid = 1'b0;
    check1("mdu1_we_c1", grf_we, 1'b0);
    check1("mdu1_qp_fifo", q_pending, 1'b1);
    tick();
    check1("mdu1_we_c2", grf_we, 1'b1);
    check32("mdu1_addr", 32'(grf_addr), 32'd5);
    check32("mdu1_data", grf_data, 32'h1234);
    check32("mdu1_pc", grf_pc, 32'h3000);
    check1("mdu1_qp_commit", q_pending, 1'b1);
    tick();
    check1("mdu1_we_after", grf_we, 1'b0);
    check1("mdu1_qp_after", q_pending, 1'b0);
    q_addr = '0;
    drain("mdu1_drain");

    // Starvation: WB wins three times over a queued head, then the head is forced
    wb_valid = 1'b1;
    wb_addr  = 5'd8;
    wb_data  = 32'h800;
    wb_pc    = 32'h4000;
    drive_mdu(1'b1, 5'd6, 32'h66, 32'h3100);
    expect_commit(5'd8, 32'h800, 32'h4000);
    tick();
    mdu_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      wb_data = 32'h800 + 32'(k);
      wb_pc   = 32'h4000 + 32'(4 * k);
      expect_commit(5'd8, wb_data, wb_pc);
      check1("starve_wb_ready", wb_ready, 1'b1);
      tick();
    end
    wb_data = 32'h804;
    wb_pc   = 32'h4010;
    expect_commit(5'd6, 32'h66, 32'h3100);
    check1("starve_force_wb_ready", wb_ready, 1'b0);
    tick();
    expect_commit(5'd8, 32'h804, 32'h4010);
    check1("starve_release_wb_ready", wb_ready, 1'b1);
    tick();
    wb_valid = 1'b0;
    drain("starve_drain");

    // Fill the FIFO under WB pressure; fifth push refused until the forced pop
    wb_valid = 1'b1;
    wb_addr  = 5'd0;
    wb_data  = 32'h0;
    wb_pc    = 32'h5200;
    for (int k = 1; k <= 4; k++) begin
      drive_mdu(1'b1, 5'(k), 32'hA0 + 32'(k), 32'h5100 + 32'(4 * k));
      expect_commit(5'(k), 32'hA0 + 32'(k), 32'h5100 + 32'(4 * k));
      check1("full_mdu_ready_pre", mdu_ready, 1'b1);
      tick();
    end
    drive_mdu(1'b1, 5'd5, 32'hA5, 32'h5114);
    expect_commit(5'd5, 32'hA5, 32'h5114);
    check1("full_mdu_ready", mdu_ready, 1'b0);
    check1("full_force_wb_ready", wb_ready, 1'b0);
    tick();
    check1("full_refill_mdu_ready", mdu_ready, 1'b1);
    tick();
    mdu_valid = 1'b0;
    wb_valid  = 1'b0;
    drain("full_drain");

    // WB write to $0: accepted, never committed
    wb_valid = 1'b1;
    wb_addr  = 5'd0;
    wb_data  = 32'hFFFF;
    wb_pc    = 32'h5000;
    q_addr   = 5'd0;
    #1;
    check1("r0_wb_ready", wb_ready, 1'b1);
    check1("r0_qp", q_pending, 1'b0);
    tick();
    wb_valid = 1'b0;
    check1("r0_we_c1", grf_we, 1'b0);
    tick();
    check1("r0_we_c2", grf_we, 1'b0);

    // Reset with three queued entries and a commit in flight
    wb_valid = 1'b1;
    wb_addr  = 5'd9;
    for (int k = 0; k <= 2; k++) begin
      wb_data = 32'h900 + 32'(k);
      wb_pc   = 32'h7000 + 32'(4 * k);
      expect_commit(5'd9, wb_data, wb_pc);
      drive_mdu(1'b1, 5'(20 + k), 32'hB0 + 32'(k), 32'h7100 + 32'(4 * k));
      check1("rstq_mdu_ready", mdu_ready, 1'b1);
      check1("rstq_wb_ready", wb_ready, 1'b1);
      tick();
    end
    mdu_valid = 1'b0;
    q_addr    = 5'd20;
    #1;
    check1("rstq_qp_before", q_pending, 1'b1);
    check1("rstq_we_before", grf_we, 1'b1);
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    wb_valid = 1'b0;
    check1("rstq_we_after", grf_we, 1'b0);
    check1("rstq_mdu_ready_after", mdu_ready, 1'b1);
    check1("rstq_wb_ready_after", wb_ready, 1'b1);
    check32("rstq_grf_data_after", grf_data, 32'h0);
    for (int a = 0; a < 32; a++) begin
      q_addr = 5'(a);
      #1;
      check1("rstq_qp_clear", q_pending, 1'b0);
    end
    q_addr = '0;
    drain("rstq_drain");

    // Steady push+pop at count 2 across several pointer wraps
    wb_valid = 1'b1;
    wb_addr  = 5'd0;
    wb_data  = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) wb_valid = 1'b0;
      drive_mdu(1'b1, 5'(k + 10), 32'(k), 32'h6000 + 32'(4 * k));
      expect_commit(5'(k + 10), 32'(k), 32'h6000 + 32'(4 * k));
      q_addr = 5'(k + 9);
      #1;
      check1("wrap_mdu_ready", mdu_ready, 1'b1);
      if (k >= 2) check1("wrap_qp_prev", q_pending, 1'b1);
      tick();
    end
    mdu_valid = 1'b0;
    q_addr    = '0;
    drain("wrap_drain");

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
